wishbone_arbiter: RTL and testbench

- Round-robin arbiter sharing one Wishbone B4 classic slave port between NUM_M masters.
- Sits between the master agents (CPU, DMA, test masters) and a single slave such as the bus's wishbone_slave.
- Arbitrates on CYC and holds the grant for the whole bus cycle, extended while LOCK is asserted.
- Muxes the granted master's signals to the slave and routes ACK/ERR/RTY back to that master only.

---
 rtl/wishbone_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_wishbone_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: round-robin arbiter that shares one Wishbone B4 classic
// slave port between NUM_M masters. The grant is taken on CYC and held for the
// whole bus cycle, and it is extended while the owning master asserts LOCK.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort tenures whose slave
// never answers within TIMEOUT_CYC strobed cycles.
module wishbone_arbiter #(
  parameter int NUM_M       = 4,
  parameter int WB_ADDR_W   = 32,
  parameter int WB_DATA_W   = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                           CLK_I,
  input  logic                           RST_I,
  input  logic [NUM_M-1:0]               M_CYC_I,
  input  logic [NUM_M-1:0]               M_STB_I,
  input  logic [NUM_M-1:0]               M_WE_I,
  input  logic [NUM_M-1:0]               M_LOCK_I,
  input  logic [NUM_M*WB_ADDR_W-1:0]     M_ADR_I,
  input  logic [NUM_M*WB_DATA_W-1:0]     M_DAT_I,
  input  logic [NUM_M*(WB_DATA_W/8)-1:0] M_SEL_I,
  output logic [WB_DATA_W-1:0]           M_DAT_O,
  output logic [NUM_M-1:0]               M_ACK_O,
  output logic [NUM_M-1:0]               M_ERR_O,
  output logic [NUM_M-1:0]               M_RTY_O,
  output logic                           S_CYC_O,
  output logic                           S_STB_O,
  output logic                           S_WE_O,
  output logic                           S_LOCK_O,
  output logic [WB_ADDR_W-1:0]           S_ADR_O,
  output logic [WB_DATA_W-1:0]           S_DAT_O,
  output logic [WB_DATA_W/8-1:0]         S_SEL_O,
  input  logic [WB_DATA_W-1:0]           S_DAT_I,
  input  logic                           S_ACK_I,
  input  logic                           S_ERR_I,
  input  logic                           S_RTY_I,
  output logic [NUM_M-1:0]               GNT_O
);

  localparam int SEL_W = WB_DATA_W / 8;
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [NUM_M-1:0] r_gnt;
  logic [NUM_M-1:0] w_gnt_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [NUM_M-1:0] w_winner;
  logic             w_win_found;
  logic             w_release;
  logic             w_timeout;

  logic [WB_ADDR_W-1:0] w_adr_term [NUM_M];
  logic [WB_DATA_W-1:0] w_dat_term [NUM_M];
  logic [SEL_W-1:0]     w_sel_term [NUM_M];

  // Reject configurations the arbiter was not built for at elaboration time.
  generate
    if (NUM_M < 2 || NUM_M > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("wishbone_arbiter: NUM_M must be 2..8 and TIMEOUT_CYC at least 1");
    end
  endgenerate

  // Per-master masked copies of the wide buses; only the owner's slice survives.
  // Response bits are steered to the owner only; a watchdog abort turns into ERR.
  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
      assign w_adr_term[gi] = r_gnt[gi] ? M_ADR_I[gi*WB_ADDR_W +: WB_ADDR_W] : '0;
      assign w_dat_term[gi] = r_gnt[gi] ? M_DAT_I[gi*WB_DATA_W +: WB_DATA_W] : '0;
      assign w_sel_term[gi] = r_gnt[gi] ? M_SEL_I[gi*SEL_W +: SEL_W] : '0;
      assign M_ACK_O[gi]    = r_gnt[gi] & S_ACK_I & ~w_timeout;
      assign M_ERR_O[gi]    = r_gnt[gi] & (S_ERR_I | w_timeout);
      assign M_RTY_O[gi]    = r_gnt[gi] & S_RTY_I & ~w_timeout;
    end
  endgenerate

  assign GNT_O   = r_gnt;
  assign M_DAT_O = S_DAT_I;

  // Index of the current owner, used to remember who released last.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_gnt[i]) begin
        w_gnt_idx = IDX_W'(i);
      end
    end
  end

  // Round-robin pick: first requester at distance 1, 2, ... NUM_M from the pointer.
  always_comb begin
    w_winner    = '0;
    w_win_found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (!w_win_found && M_CYC_I[i] && (((int'(r_ptr) + k) % NUM_M) == i)) begin
          w_winner[i] = 1'b1;
          w_win_found = 1'b1;
        end
      end
    end
  end

  // Tenure ends when the owner drops both CYC and LOCK, or the watchdog fires.
  assign w_release = (r_state == ST_OWNED) &&
                     ((~|(r_gnt & M_CYC_I) && ~|(r_gnt & M_LOCK_I)) || w_timeout);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] w_to_cnt_next;
  logic             w_resp;

  assign w_resp    = S_ACK_I | S_ERR_I | S_RTY_I;
  assign w_timeout = (r_state == ST_OWNED) && (r_to_cnt == CNT_W'(TIMEOUT_CYC));

  // Count strobed cycles without a response; idle time and any response clear it.
  always_comb begin
    w_to_cnt_next = r_to_cnt;
    if (r_state != ST_OWNED) begin
      w_to_cnt_next = '0;
    end else if (w_resp) begin
      w_to_cnt_next = '0;
    end else if (S_STB_O) begin
      w_to_cnt_next = r_to_cnt + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_next;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State, grant and round-robin pointer registers.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= IDX_W'(NUM_M - 1);
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Next-state logic: arbitrate only from IDLE, so a grant never changes mid-cycle.
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|M_CYC_I) begin
          w_state_next = ST_OWNED;
          w_gnt_next   = w_winner;
        end
      end
      ST_OWNED: begin
        if (w_release) begin
          w_state_next = ST_IDLE;
          w_gnt_next   = '0;
          w_ptr_next   = w_gnt_idx;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  // Output logic: slave side follows the owner; everything reads 0 while idle.
  always_comb begin
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_SEL_O = '0;
    for (int i = 0; i < NUM_M; i++) begin
      S_ADR_O = S_ADR_O | w_adr_term[i];
      S_DAT_O = S_DAT_O | w_dat_term[i];
      S_SEL_O = S_SEL_O | w_sel_term[i];
    end
    S_CYC_O  = (|(r_gnt & M_CYC_I)) & ~w_timeout;
    S_STB_O  = (|(r_gnt & M_STB_I)) & ~w_timeout;
    S_WE_O   = |(r_gnt & M_WE_I);
    S_LOCK_O = |(r_gnt & M_LOCK_I);
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Testbench for wishbone_arbiter: vector tables, directed multi-cycle
// sequences and a randomized run checked against a tenure-level model.
module tb_wishbone_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we, m_lock;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack, m_err, m_rty;
  logic            s_cyc, s_stb, s_we, s_lock;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack, s_err, s_rty;
  logic [N-1:0]    gnt;

  int n_tests = 0;
  int n_fail  = 0;

  wishbone_arbiter #(
    .NUM_M(N), .WB_ADDR_W(AW), .WB_DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK_I(clk), .RST_I(rst_n),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_WE_I(m_we), .M_LOCK_I(m_lock),
    .M_ADR_I(m_adr), .M_DAT_I(m_dat), .M_SEL_I(m_sel),
    .M_DAT_O(m_dat_o), .M_ACK_O(m_ack), .M_ERR_O(m_err), .M_RTY_O(m_rty),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_LOCK_O(s_lock),
    .S_ADR_O(s_adr), .S_DAT_O(s_dat_o), .S_SEL_O(s_sel),
    .S_DAT_I(s_dat_i), .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty),
    .GNT_O(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus with the outputs expected in that same cycle.
  typedef struct {
    logic [N-1:0] cyc;
    logic [N-1:0] lock;
    logic         ack, err, rty;
    logic [N-1:0] e_gnt;
    logic         e_scyc;
    logic [AW-1:0] e_adr;
    logic [N-1:0] e_ack, e_err, e_rty;
  } vec_t;

  vec_t tbl_a [10];
  vec_t tbl_b [10];

  task automatic run_vec(input vec_t v, input int idx);
    m_cyc = v.cyc; m_stb = v.cyc; m_lock = v.lock;
    s_ack = v.ack; s_err = v.err; s_rty = v.rty;
    @(negedge clk);
    $display("[TB] vec %0d cyc=%b lock=%b gnt=%b s_cyc=%b adr=%h ack=%b err=%b rty=%b",
             idx, v.cyc, v.lock, gnt, s_cyc, s_adr, m_ack, m_err, m_rty);
    chk($sformatf("vec%0d_gnt", idx), 64'(gnt), 64'(v.e_gnt));
    chk($sformatf("vec%0d_scyc", idx), 64'(s_cyc), 64'(v.e_scyc));
    chk($sformatf("vec%0d_adr", idx), 64'(s_adr), 64'(v.e_adr));
    chk($sformatf("vec%0d_ack", idx), 64'(m_ack), 64'(v.e_ack));
    chk($sformatf("vec%0d_err", idx), 64'(m_err), 64'(v.e_err));
    chk($sformatf("vec%0d_rty", idx), 64'(m_rty), 64'(v.e_rty));
    @(posedge clk); #1;
  endtask

  // Reference model: who owns the bus, where the rotation resumes, stall count.
  int owner;
  int last;
  int stall;

  function automatic logic model_to();
`ifdef WB_ARB_TIMEOUT_EN
    return (owner >= 0) && (stall == TO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    logic to;
    logic resp;
    to   = model_to();
    resp = s_ack | s_err | s_rty;
    if (owner < 0) begin
      stall = 0;
      for (int k = 1; k <= N; k++) begin
        if (owner < 0 && m_cyc[(last + k) % N]) owner = (last + k) % N;
      end
    end else if ((!m_cyc[owner] && !m_lock[owner]) || to) begin
      last  = owner;
      owner = -1;
      stall = 0;
    end else if (resp) begin
      stall = 0;
    end else if (m_stb[owner]) begin
      stall = stall + 1;
    end
  endtask

  task automatic model_check(input int c);
    logic to;
    logic [N-1:0] e_gnt, e_ack, e_err, e_rty;
    logic e_cyc, e_stb, e_we, e_lock;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    to = model_to();
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_lock = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (owner >= 0) begin
      e_gnt[owner] = 1'b1;
      e_cyc  = m_cyc[owner] & ~to;
      e_stb  = m_stb[owner] & ~to;
      e_we   = m_we[owner];
      e_lock = m_lock[owner];
      e_adr  = m_adr[owner*AW +: AW];
      e_dat  = m_dat[owner*DW +: DW];
      e_sel  = m_sel[owner*SW +: SW];
      e_ack[owner] = s_ack & ~to;
      e_err[owner] = s_err | to;
      e_rty[owner] = s_rty & ~to;
    end
    $display("[TB] rnd %0d cyc=%b lock=%b owner=%0d gnt=%b ack=%b err=%b rty=%b",
             c, m_cyc, m_lock, owner, gnt, m_ack, m_err, m_rty);
    chk("rnd_gnt", 64'(gnt), 64'(e_gnt));
    chk("rnd_s_cyc", 64'(s_cyc), 64'(e_cyc));
    chk("rnd_s_stb", 64'(s_stb), 64'(e_stb));
    chk("rnd_s_we", 64'(s_we), 64'(e_we));
    chk("rnd_s_lock", 64'(s_lock), 64'(e_lock));
    chk("rnd_s_adr", 64'(s_adr), 64'(e_adr));
    chk("rnd_s_dat", 64'(s_dat_o), 64'(e_dat));
    chk("rnd_s_sel", 64'(s_sel), 64'(e_sel));
    chk("rnd_m_ack", 64'(m_ack), 64'(e_ack));
    chk("rnd_m_err", 64'(m_err), 64'(e_err));
    chk("rnd_m_rty", 64'(m_rty), 64'(e_rty));
    chk("rnd_m_dat", 64'(m_dat_o), 64'(s_dat_i));
  endtask

  initial begin
    logic [N-1:0] e;
    int w;
    // Single request / response routing / request during another tenure.
    tbl_a[0] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h000, 4'b0000, 4'b0000, 4'b0000};
    tbl_a[1] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 32'h010, 4'b0001, 4'b0000, 4'b0000};
    tbl_a[2] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h010, 4'b0000, 4'b0000, 4'b0000};
    tbl_a[3] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h000, 4'b0000, 4'b0000, 4'b0000};
    tbl_a[4] = '{4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h000, 4'b0000, 4'b0000, 4'b0000};
    tbl_a[5] = '{4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, 32'h310, 4'b0000, 4'b1000, 4'b0000};
    tbl_a[6] = '{4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h310, 4'b1000, 4'b0000, 4'b0000};
    tbl_a[7] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h310, 4'b0000, 4'b0000, 4'b0000};
    tbl_a[8] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h000, 4'b0000, 4'b0000, 4'b0000};
    tbl_a[9] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h110, 4'b0000, 4'b0000, 4'b0010};
    // Master 2 locks across a 3-cycle CYC gap while master 1 waits.
    tbl_b[0] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h000, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[1] = '{4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 32'h210, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[2] = '{4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 32'h210, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[3] = '{4'b0010, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h210, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[4] = '{4'b0010, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h210, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[5] = '{4'b0010, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h210, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[6] = '{4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 32'h210, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[7] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h210, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[8] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h000, 4'b0000, 4'b0000, 4'b0000};
    tbl_b[9] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 32'h110, 4'b0000, 4'b0000, 4'b0000};

    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = 4'b0101; m_lock = '0;
    m_adr = {32'h310, 32'h210, 32'h110, 32'h010};
    m_dat = {32'hdddd_0003, 32'hdddd_0002, 32'hdddd_0001, 32'hdddd_0000};
    m_sel = 16'hf3c1;
    s_dat_i = 32'h1234_5678; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset gnt=%b s_cyc=%b adr=%h", gnt, s_cyc, s_adr);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc), 64'h0);
    chk("rst_s_adr", 64'(s_adr), 64'h0);
    chk("rst_m_dat", 64'(m_dat_o), 64'h1234_5678);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(tbl_a[i], i);

    // Asynchronous reset in the middle of master 1's tenure.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-tenure gnt=%b s_cyc=%b", gnt, s_cyc);
    chk("arst_gnt", 64'(gnt), 64'h0);
    chk("arst_s_cyc", 64'(s_cyc), 64'h0);
    @(posedge clk); #1;
    m_cyc = 4'b1111; m_stb = 4'b1111; s_ack = 1'b1; s_rty = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All four request continuously: strict rotation with an idle cycle between.
    for (int t = 0; t < 8; t++) begin
      e = 4'b0001 << (t % 4);
      w = 0;
      @(negedge clk);
      while (gnt == '0 && w < 6) begin
        @(negedge clk);
        w++;
      end
      $display("[TB] rr tenure %0d gnt=%b", t, gnt);
      chk($sformatf("rr%0d_gnt", t), 64'(gnt), 64'(e));
      @(posedge clk); #1;
      m_cyc = 4'b1111 & ~e; m_stb = m_cyc;
      @(posedge clk); #1;
      m_cyc = 4'b1111; m_stb = 4'b1111;
      @(negedge clk);
      chk($sformatf("rr%0d_idle_scyc", t), 64'(s_cyc), 64'h0);
      chk($sformatf("rr%0d_idle_gnt", t), 64'(gnt), 64'h0);
    end
    @(posedge clk); #1;
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(tbl_b[i], 10 + i);

    // Master 0 strobes a slave that never answers.
    m_cyc = 4'b0001; m_stb = 4'b0001; m_lock = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    w = 0;
    @(negedge clk);
    while (gnt != 4'b0001 && w < 6) begin
      @(negedge clk);
      w++;
    end
    chk("stall_gnt", 64'(gnt), 64'h1);
`ifdef WB_ARB_TIMEOUT_EN
    // Owned cycle 1 has count 0; the abort shows once TO stalled cycles are counted.
    w = 1;
    while (!m_err[0] && w < 3 * TO) begin
      @(negedge clk);
      w++;
    end
    $display("[TB] watchdog err at owned cycle %0d s_cyc=%b", w, s_cyc);
    chk("wd_cycle", 64'(w), 64'(TO + 1));
    chk("wd_err", 64'(m_err), 64'h1);
    chk("wd_s_cyc", 64'(s_cyc), 64'h0);
    @(negedge clk);
    chk("wd_idle_gnt", 64'(gnt), 64'h0);
`else
    repeat (99) @(negedge clk);
    $display("[TB] stall cycle 100 gnt=%b s_cyc=%b err=%b", gnt, s_cyc, m_err);
    chk("hold100_gnt", 64'(gnt), 64'h1);
    chk("hold100_s_cyc", 64'(s_cyc), 64'h1);
    chk("hold100_err", 64'(m_err), 64'h0);
`endif

    // Randomized traffic against the reference model, from a fresh reset.
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_lock = '0;
    @(negedge clk);
    rst_n = 1'b1;
    owner = -1; last = N - 1; stall = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < N; i++) begin
        m_cyc[i]  = ($urandom_range(0, 9) < 6);
        m_stb[i]  = ($urandom_range(0, 3) != 0);
        m_we[i]   = 1'($urandom_range(0, 1));
        m_lock[i] = ($urandom_range(0, 9) == 0);
        m_adr[i*AW +: AW] = $urandom;
        m_dat[i*DW +: DW] = $urandom;
        m_sel[i*SW +: SW] = 4'($urandom_range(0, 15));
      end
      s_dat_i = $urandom;
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 7) == 0);
      s_rty   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      model_check(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
